lz77_decoder: RTL
=================

Name: lz77_decoder

Overview:
- Streaming LZ77 decompressor; inverse of lz77_top.
- Consumes the 14-bit token stream that lz77_top emits on encoded_data/encoded_valid and rebuilds the original byte stream, one byte per cycle.
- Holds a circular history window of the most recent decoded bytes for back-reference copies.
- Used in the round-trip compress/decompress bench and as the receive-side block in the datapath.

Parameters:
- OFFSET_W, 9: offset field width; history depth = 2**OFFSET_W bytes.
- LEN_W, 4: length field width; match length 1..2**LEN_W-1.
- TOKEN_W, 14: token width; must equal 1+OFFSET_W+LEN_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- start  input  1  one-cycle pulse: clears history fill count, error, done.
- token_in  input  TOKEN_W  token.
- token_valid  input  1  token_in valid.
- token_last  input  1  qualifies token_in as the final token of the stream.
- token_ready  output  1  decoder accepts token this cycle.
- data_out  output  8  decoded byte.
- data_valid  output  1  data_out valid.
- data_ready  input  1  downstream accepts data_out.
- done  output  1  high after the final byte of the last token has been accepted.
- error  output  1  sticky illegal-token flag.
- token_count  output  32  tokens accepted (LZ77_DEC_STATS_EN only).
- byte_count  output  32  bytes delivered (LZ77_DEC_STATS_EN only).

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, state IDLE, wr_ptr 0, fill 0. History contents are don't-care.
- Token format:
  - bit[TOKEN_W-1]=0 is a literal: byte in [7:0]; bits [TOKEN_W-2:8] ignored.
  - bit[TOKEN_W-1]=1 is a match: offset in [TOKEN_W-2:LEN_W], length in [LEN_W-1:0].
- Handshakes:
  - Token transfer occurs on token_valid&&token_ready.
  - Byte transfer occurs on data_valid&&data_ready.
  - data_out/data_valid are registered and held stable while data_valid&&!data_ready.
- token_ready = (state==IDLE) && (!data_valid || data_ready) && !done.
- State machine:
  - IDLE, literal accepted: data_out<=byte, data_valid<=1, byte written to hist[wr_ptr], wr_ptr++, fill saturates at 2**OFFSET_W.
  - IDLE, legal match accepted: latch rd_ptr=wr_ptr-offset (mod depth) and remaining=length, then go to COPY.
  - COPY: each cycle the output register is free (!data_valid||data_ready), emit hist[rd_ptr], write it to hist[wr_ptr], increment both pointers, decrement remaining. When remaining reaches 0, return to IDLE.
  - COPY, output register not free: stall; pointers and remaining hold.
- Overlapping copies (offset<length) must reproduce run-length behaviour. Each copied byte is written before its own later read. History read is combinational from the register array; there is no read-after-write hazard at the same address.
- Latency: first byte of any token is valid the cycle after acceptance. Throughput is 1 byte/cycle absent backpressure. A match occupies length cycles, with no IDLE bubble required between tokens.
- Pointer arithmetic is modulo 2**OFFSET_W; wrap-around is transparent.
- Illegal match is any of: length==0, offset==0, or offset>fill.
  - Token is consumed; error<=1 (sticky); no bytes emitted; stay in IDLE.
- token_last: latched when accepted. done<=1 the cycle after the final byte of that token transfers. For an illegal last token, done asserts the next cycle.
- While done=1, token_ready=0 until start.
- start:
  - In any state: clears done, error and fill; returns to IDLE; aborts any COPY.
  - Clears data_valid unless a pending byte is being accepted that same cycle.
  - start takes priority over a simultaneous token transfer; that token is not accepted.

Optional Feature:
- Macro: LZ77_DEC_STATS_EN.
- Defined:
  - token_count increments per accepted token, including illegal tokens.
  - byte_count increments per byte transfer.
  - Both wrap at 2**32 and clear on reset or start.
- Undefined: no counter logic; token_count and byte_count are tied to 0.

Test Plan:
- Literal 14'h0041, 14'h0042 (last) -> data_out 0x41 then 0x42 on consecutive cycles; done=1 one cycle after 0x42 transfers; error=0.
- Literal 0x41, literal 0x42, match 14'h2025 (offset 2, length 5, last) -> bytes 41 42 41 42 41 42 41; token_ready=0 for the 4 cycles after the match is accepted.
- Literal 0x5A then 14'h201F (offset 1, length 15) -> 16 bytes of 0x5A (overlap copy).
- Two literals, then match 14'h2032 (offset 3 > fill 2) -> error=1, no bytes emitted; following literal 0x43 decodes normally; error stays 1 until start.
- Write 600 literals (i mod 256), then match offset 511 length 3 -> bytes (89,90,91) mod 256 (indices 89..91); toggling data_ready 50% yields the identical sequence with data_out stable while stalled.
- Assert rst low mid-COPY -> all outputs 0 immediately; after start, literal 0x41 decodes correctly.

Source files
------------

// File: rtl/lz77_decoder.sv
`default_nettype none
// ============================================================================
// Module   : lz77_decoder
// Summary  : Streaming LZ77 token decoder with a circular history window that
//            emits one byte per cycle. Optional counters: LZ77_DEC_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lz77_decoder #(
  parameter int OFFSET_W = 9,
  parameter int LEN_W    = 4,
  parameter int TOKEN_W  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TOKEN_W-1:0] token_in,
  input  logic               token_valid,
  input  logic               token_last,
  output logic               token_ready,
  output logic [7:0]         data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               done,
  output logic               error,
  output logic [31:0]        token_count,
  output logic [31:0]        byte_count
);

  localparam int                c_DEPTH    = 2**OFFSET_W;
  localparam logic [OFFSET_W:0] c_FILL_MAX = (OFFSET_W+1)'(c_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } state_t;

  state_t              r_state;
  logic [7:0]          r_hist [c_DEPTH];
  logic [OFFSET_W-1:0] r_wr_ptr;
  logic [OFFSET_W-1:0] r_rd_ptr;
  logic [OFFSET_W:0]   r_fill;
  logic [LEN_W-1:0]    r_remaining;
  logic                r_last;
  logic [7:0]          r_data_out;
  logic                r_data_valid;
  logic                r_done;
  logic                r_error;

  logic                w_out_free;
  logic                w_xfer;
  logic                w_accept;
  logic                w_is_match;
  logic [OFFSET_W-1:0] w_offset;
  logic [LEN_W-1:0]    w_length;
  logic                w_match_ok;
  logic                w_lit_acc;
  logic                w_match_acc;
  logic                w_bad_acc;
  logic                w_copy_emit;
  logic                w_emit;
  logic [OFFSET_W-1:0] w_rd_addr;
  logic [7:0]          w_emit_byte;
  logic [OFFSET_W:0]   w_fill_next;

  assign w_out_free  = !r_data_valid || data_ready;
  assign w_xfer      = r_data_valid && data_ready;
  // Held low during reset so every output reads 0 while rst is asserted.
  assign token_ready = rst && (r_state == ST_IDLE) && w_out_free && !r_done;
  assign w_accept    = token_valid && token_ready && !start;

  assign w_is_match  = token_in[TOKEN_W-1];
  assign w_offset    = token_in[TOKEN_W-2:LEN_W];
  assign w_length    = token_in[LEN_W-1:0];
  assign w_match_ok  = (w_length != '0) && (w_offset != '0) && ({1'b0, w_offset} <= r_fill);

  assign w_lit_acc   = w_accept && !w_is_match;
  assign w_match_acc = w_accept && w_is_match && w_match_ok;
  assign w_bad_acc   = w_accept && w_is_match && !w_match_ok;
  assign w_copy_emit = (r_state == ST_COPY) && w_out_free && !start;
  assign w_emit      = w_lit_acc || w_match_acc || w_copy_emit;

  // A match emits its first byte in the acceptance cycle, straight from wr_ptr-offset.
  assign w_rd_addr   = (r_state == ST_IDLE) ? (r_wr_ptr - w_offset) : r_rd_ptr;
  assign w_emit_byte = w_lit_acc ? token_in[7:0] : r_hist[w_rd_addr];
  assign w_fill_next = (r_fill == c_FILL_MAX) ? r_fill : r_fill + (OFFSET_W+1)'(1);

  always_ff @(posedge clk) begin
    if (w_emit) begin
      r_hist[r_wr_ptr] <= w_emit_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_remaining  <= '0;
      r_last       <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else if (start) begin
      r_state      <= ST_IDLE;
      r_fill       <= '0;
      r_remaining  <= '0;
      r_last       <= 1'b0;
      r_data_valid <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_data_valid <= 1'b0;
      end
      // In IDLE with a latched last flag, the byte in the register is the final one.
      if (r_last && (r_state == ST_IDLE) && w_xfer) begin
        r_done <= 1'b1;
        r_last <= 1'b0;
      end
      if (w_emit) begin
        r_data_out   <= w_emit_byte;
        r_data_valid <= 1'b1;
        r_wr_ptr     <= r_wr_ptr + OFFSET_W'(1);
        r_fill       <= w_fill_next;
      end
      if (w_lit_acc) begin
        r_last <= token_last;
      end
      if (w_match_acc) begin
        r_last      <= token_last;
        r_rd_ptr    <= w_rd_addr + OFFSET_W'(1);
        r_remaining <= w_length - LEN_W'(1);
        if (w_length != LEN_W'(1)) begin
          r_state <= ST_COPY;
        end
      end
      if (w_bad_acc) begin
        r_error <= 1'b1;
        if (token_last) begin
          r_done <= 1'b1;
        end
      end
      if (w_copy_emit) begin
        r_rd_ptr    <= r_rd_ptr + OFFSET_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
        if (r_remaining == LEN_W'(1)) begin
          r_state <= ST_IDLE;
        end
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign done       = r_done;
  assign error      = r_error;

`ifdef LZ77_DEC_STATS_EN
  logic [31:0] r_token_count;
  logic [31:0] r_byte_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_token_count <= '0;
      r_byte_count  <= '0;
    end else if (start) begin
      r_token_count <= '0;
      r_byte_count  <= '0;
    end else begin
      if (w_accept) begin
        r_token_count <= r_token_count + 32'd1;
      end
      if (w_xfer) begin
        r_byte_count <= r_byte_count + 32'd1;
      end
    end
  end

  assign token_count = r_token_count;
  assign byte_count  = r_byte_count;
`else
  assign token_count = '0;
  assign byte_count  = '0;
`endif

endmodule
`default_nettype wire
